// File: rtl/sc_lane_shift_ctrl_pkg.sv
// Shared definitions for the lane shift controller and its prescaler.
// Holds the controller state encoding, the lane-register shift codes and the
// top level index of the default 2-bit level range.
package sc_lane_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10
  } shift_e;

  localparam int unsigned LEVEL_WIDTH_DEF = 2;
  localparam int unsigned MAX_LEVEL       = (1 << LEVEL_WIDTH_DEF) - 1;

endpackage

// File: rtl/sc_lane_shift_ctrl_prescaler.sv
// Purpose: speed prescaler; counts RUN cycles and flags the last one of each period.
// Latency: tick_o is registered and high during the cycle whose count is period-1.
// Backpressure: none; en_i freezes the count, clr_i restarts it at zero.
// Ports:
//   clk_i, rst_i  clock (rising edge) and async active-high reset
//   clr_i         load count with zero on this edge (has priority over en_i)
//   en_i          advance count on this edge, wrapping at period_i-1
//   arm_i         next cycle is a counting cycle; ticks are only raised when set
//   period_i      current period in clocks, must be >= 1
//   tick_o        registered one-cycle tick
module sc_lane_prescaler #(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 arm_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  output logic                 tick_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] last_cnt;
  logic                 tick_q, tick_d;

  assign last_cnt = period_i - CNT_WIDTH'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == last_cnt) ? '0 : cnt_q + CNT_WIDTH'(1);
    end
    // Look at the value the counter will hold next cycle so the tick lines up
    // with the cycle in which the count actually reaches period-1.
    tick_d = arm_i && (cnt_d == last_cnt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/sc_lane_shift_ctrl.sv
// Purpose: per-lane initiator of clear/load/shift strobes for the lane register.
// Latency: every output is registered; strobes appear the cycle after the request.
// Backpressure: none; CLEAR and LOAD always complete, inputs during them are ignored.
// Ports:
//   SC_LANECTRL_CLOCK_50 / SC_LANECTRL_RESET_InHigh   clock and async reset
//   SC_LANECTRL_{start,stop,levelup,pause}_InLow       active-low requests
//   SC_LANECTRL_clear_OutLow / load_OutLow             active-low lane strobes
//   SC_LANECTRL_shiftselection_Out                     shift code, 00 when idle
//   SC_LANECTRL_level_Out                              level, pattern-ROM index
//   SC_LANECTRL_running_OutHigh                        high in RUN and PAUSE
module sc_lane_shift_ctrl
  import sc_lane_shift_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH   = 24,
  parameter logic [CNT_WIDTH-1:0] BASE_PERIOD = 24'd10000000,
  parameter logic [1:0]           SHIFT_DIR   = SHIFT_LEFT,
  parameter int unsigned          LEVEL_WIDTH = 2
) (
  input  logic                   SC_LANECTRL_CLOCK_50,
  input  logic                   SC_LANECTRL_RESET_InHigh,
  input  logic                   SC_LANECTRL_start_InLow,
  input  logic                   SC_LANECTRL_stop_InLow,
  input  logic                   SC_LANECTRL_levelup_InLow,
  input  logic                   SC_LANECTRL_pause_InLow,
  output logic                   SC_LANECTRL_clear_OutLow,
  output logic                   SC_LANECTRL_load_OutLow,
  output logic [1:0]             SC_LANECTRL_shiftselection_Out,
  output logic [LEVEL_WIDTH-1:0] SC_LANECTRL_level_Out,
  output logic                   SC_LANECTRL_running_OutHigh
);

  localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP = {LEVEL_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic                   reload_q, reload_d;   // CLEAR continues into LOAD
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   clear_n_q, clear_n_d;
  logic                   load_n_q, load_n_d;
  logic                   running_q, running_d;
  logic [CNT_WIDTH-1:0]   period_shr, period;
  logic                   tick;

  // Each level halves the period; deep levels saturate at one clock.
  assign period_shr = BASE_PERIOD >> level_q;
  assign period     = (period_shr == '0) ? CNT_WIDTH'(1) : period_shr;

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    level_d  = level_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!SC_LANECTRL_start_InLow) begin
          state_d  = ST_CLEAR;
          reload_d = 1'b1;
        end
      end
      ST_CLEAR: state_d = reload_q ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN, ST_PAUSE: begin
        if (!SC_LANECTRL_stop_InLow) begin
          state_d  = ST_CLEAR;
          reload_d = 1'b0;
          level_d  = '0;
        end else if (!SC_LANECTRL_levelup_InLow) begin
          // Level changes on entry to CLEAR so the ROM is settled by LOAD.
          state_d  = ST_CLEAR;
          reload_d = 1'b1;
          level_d  = (level_q == LEVEL_TOP) ? level_q : level_q + LEVEL_WIDTH'(1);
        end else if (!SC_LANECTRL_pause_InLow) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they register with it.
    clear_n_d = (state_d != ST_CLEAR);
    load_n_d  = (state_d != ST_LOAD);
    running_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge SC_LANECTRL_CLOCK_50 or posedge SC_LANECTRL_RESET_InHigh) begin
    if (SC_LANECTRL_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      reload_q  <= 1'b0;
      level_q   <= '0;
      clear_n_q <= 1'b1;
      load_n_q  <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      level_q   <= level_d;
      clear_n_q <= clear_n_d;
      load_n_q  <= load_n_d;
      running_q <= running_d;
    end
  end

  // The count restarts on the LOAD edge, advances after every RUN cycle and is
  // held through PAUSE; ticks are only raised for cycles that will be in RUN.
  sc_lane_prescaler #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_prescaler (
    .clk_i   (SC_LANECTRL_CLOCK_50),
    .rst_i   (SC_LANECTRL_RESET_InHigh),
    .clr_i   (state_q == ST_LOAD),
    .en_i    (state_q == ST_RUN),
    .arm_i   (state_d == ST_RUN),
    .period_i(period),
    .tick_o  (tick)
  );

  assign SC_LANECTRL_clear_OutLow       = clear_n_q;
  assign SC_LANECTRL_load_OutLow        = load_n_q;
  assign SC_LANECTRL_shiftselection_Out = tick ? SHIFT_DIR : 2'(SHIFT_NONE);
  assign SC_LANECTRL_level_Out          = level_q;
  assign SC_LANECTRL_running_OutHigh    = running_q;

endmodule

// File: doc/sc_lane_shift_ctrl.md
Name: sc_lane_shift_ctrl

Overview:
- Control-side initiator for the background/lane register: generates the active-low clear, active-low load and 2-bit shift-selection strobes that the lane register consumes.
- Sequences a lane through clear, pattern load and periodic rotation at a level-dependent speed.
- Exposes the current level so top-level logic can select the load pattern for the lane register's data input.
- One instance per lane. It sits between the game FSM and the lane register.

Parameters:
- CNT_WIDTH, 24, width of the speed prescaler counter.
- BASE_PERIOD, 24'd10000000, clocks between shifts at level 0 (0.2 s at 50 MHz).
- SHIFT_DIR, 2'b01, shift code issued on each tick: 01 = rotate left, 10 = rotate right.
- LEVEL_WIDTH, 2, width of the level index.

Ports:
- SC_LANECTRL_CLOCK_50  in  1  system clock, rising edge.
- SC_LANECTRL_RESET_InHigh  in  1  asynchronous reset, active-high.
- SC_LANECTRL_start_InLow  in  1  start request, sampled in IDLE.
- SC_LANECTRL_stop_InLow  in  1  stop request: clear lane and return to IDLE.
- SC_LANECTRL_levelup_InLow  in  1  one-cycle level-advance request.
- SC_LANECTRL_pause_InLow  in  1  level-sensitive hold of rotation.
- SC_LANECTRL_clear_OutLow  out  1  to lane register clear input.
- SC_LANECTRL_load_OutLow  out  1  to lane register load input.
- SC_LANECTRL_shiftselection_Out  out  2  to lane register shift-select input.
- SC_LANECTRL_level_Out  out  LEVEL_WIDTH  current level, used as the pattern-ROM index.
- SC_LANECTRL_running_OutHigh  out  1  high while in RUN or PAUSE.

Behaviour:
- Reset (async, active-high) forces: state IDLE; clear_OutLow=1; load_OutLow=1; shiftselection=00; level=0; counter=0; running=0.
- All outputs are registered. Clear, load and shift strobes are mutually exclusive in every cycle.

State machine:
- IDLE: all strobes inactive. If start_InLow=0, go to CLEAR.
- CLEAR: one cycle with clear_OutLow=0.
  - Next state is LOAD if the entry came from start or levelup.
  - Next state is IDLE if the entry came from stop. Stop also sets level=0.
- LOAD: one cycle with load_OutLow=0. Next state RUN; counter=0.
- RUN:
  - Counter increments each cycle.
  - When counter==PERIOD-1: shiftselection=SHIFT_DIR for exactly one cycle, and the counter wraps to 0.
  - Otherwise shiftselection=00.
- PAUSE: entered from RUN while pause_InLow=0.
  - Counter frozen; shiftselection=00.
  - Return to RUN when pause_InLow=1; counting resumes from the held value.

Rates and arithmetic:
- PERIOD = BASE_PERIOD >> level, saturated to a minimum of 1.
- With PERIOD=1, the shift strobe is asserted every RUN cycle.
- The first shift occurs in the PERIOD-th cycle spent in RUN.

Priority in RUN/PAUSE (highest first): stop > levelup > pause > tick.
- levelup: level <= min(level+1, 2^LEVEL_WIDTH-1), then CLEAR, LOAD, RUN. The new level is visible during the LOAD cycle, so the ROM output is valid at load.
- levelup at maximum level: level is held, and the CLEAR/LOAD/RUN reload still occurs.
- stop and levelup in the same cycle: stop wins and the level resets to 0.
- start, levelup and pause in IDLE are ignored. stop in IDLE is ignored.
- Inputs received during CLEAR or LOAD are ignored; those states always complete.

Other rules:
- running_OutHigh=1 in RUN and PAUSE only.
- Reset asserted mid-operation immediately returns all outputs to their reset values. No strobe is completed after reset.

Decomposition:
- Shared include/package holds:
  - state encodings: IDLE, CLEAR, LOAD, RUN, PAUSE;
  - shift codes: SHIFT_NONE=00, SHIFT_LEFT=01, SHIFT_RIGHT=10;
  - MAX_LEVEL constant.
- One natural sub-module, sc_lane_prescaler:
  - enable/clear-controlled counter with period input and one-cycle tick output;
  - the controller FSM instantiates it.

Test Plan (BASE_PERIOD=8, SHIFT_DIR=01):
- Reset, then start_InLow=0 for 1 cycle → clear_OutLow=0 in cycle 1, load_OutLow=0 in cycle 2, RUN entered; shiftselection=01 in the 8th RUN cycle, then every 8 cycles; running=1.
- levelup pulse in RUN at level 0 → one clear cycle, one load cycle with level_Out=1, shift period becomes 4; three more levelups → level saturates at 3, period 1, shiftselection=01 every RUN cycle.
- In RUN at counter=5, hold pause_InLow=0 for 20 cycles → shiftselection stays 00, running=1; on release, shift strobe occurs 3 cycles later.
- stop_InLow and levelup_InLow low in the same cycle → one clear cycle, then IDLE, level_Out=0, running=0, no load strobe.
- Assert RESET_InHigh mid-RUN one cycle before a tick → outputs immediately return to 1/1/00, level 0; no shift strobe is emitted after reset.
- start held low during CLEAR/LOAD, and pause low during LOAD → sequence unchanged, then RUN goes to PAUSE on the next cycle with pause still low.
